// File: rtl/watch_pkg.sv
// Shared constants, mode encoding and small helpers for the watch core.
package watch_pkg;

  localparam int unsigned FIELD_W     = 8;
  localparam int unsigned SEC_MAX     = 59;
  localparam int unsigned MIN_MAX     = 59;
  localparam int unsigned HOUR_MAX    = 23;
  localparam int unsigned ALARM_RST_H = 12;
  localparam int unsigned ALARM_RST_M = 0;

  typedef enum logic [1:0] {
    TIMER,
    SET,
    ALARM
  } mode_t;

  // Increment a time field, wrapping to zero after its maximum.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                  input logic [FIELD_W-1:0] max);
    return (value == max) ? '0 : value + FIELD_W'(1);
  endfunction

  // Set has priority over Alarm; neither selects Timer.
  function automatic mode_t decode_mode(input logic set_lvl, input logic alerm_lvl);
    if (set_lvl) begin
      return SET;
    end
    if (alerm_lvl) begin
      return ALARM;
    end
    return TIMER;
  endfunction

endpackage

// File: rtl/second_tick.sv
// Prescaler: counts 0..second_cnt-1 and flags the last count as the 1 Hz tick.
module second_tick #(
  parameter int unsigned second_cnt = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CNT_W = (second_cnt > 1) ? $clog2(second_cnt) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(second_cnt - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = (count == CNT_LAST);

  // Free-running divider, wraps on the tick cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/watch_control.sv
// Watch core: 24-hour time of day, hh:mm alarm, mode-dependent adjust and display.
module watch_control
  import watch_pkg::*;
#(
  parameter int unsigned second_cnt = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set,
  input  logic        alerm,
  input  logic        alerm_switch,
  input  logic        minute_set,
  input  logic        hour_set,
  output logic [23:0] time_data,
  output logic        alerm_equal
);

  logic [FIELD_W-1:0] sec;
  logic [FIELD_W-1:0] min;
  logic [FIELD_W-1:0] hour;
  logic [FIELD_W-1:0] alarm_min;
  logic [FIELD_W-1:0] alarm_hour;
  logic               tick_c;
  mode_t              mode_c;

  second_tick #(
    .second_cnt(second_cnt)
  ) u_second_tick (
    .clock (clock),
    .reset (reset),
    .tick_c(tick_c)
  );

  assign mode_c = decode_mode(set, alerm);

  // Time of day: counts in Timer/Alarm modes, button-adjusted in Set mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (tick_c) begin
      unique case (mode_c)
        SET: begin
          if (minute_set) begin
            min <= wrap_inc(min, FIELD_W'(MIN_MAX));
          end
          if (hour_set) begin
            hour <= wrap_inc(hour, FIELD_W'(HOUR_MAX));
          end
        end
        TIMER, ALARM: begin
          sec <= wrap_inc(sec, FIELD_W'(SEC_MAX));
          if (sec == FIELD_W'(SEC_MAX)) begin
            min <= wrap_inc(min, FIELD_W'(MIN_MAX));
            if (min == FIELD_W'(MIN_MAX)) begin
              hour <= wrap_inc(hour, FIELD_W'(HOUR_MAX));
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Alarm register: button-adjusted only in Alarm mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      alarm_min  <= FIELD_W'(ALARM_RST_M);
      alarm_hour <= FIELD_W'(ALARM_RST_H);
    end else if (tick_c && (mode_c == ALARM)) begin
      if (minute_set) begin
        alarm_min <= wrap_inc(alarm_min, FIELD_W'(MIN_MAX));
      end
      if (hour_set) begin
        alarm_hour <= wrap_inc(alarm_hour, FIELD_W'(HOUR_MAX));
      end
    end
  end

  // Registered alarm match, evaluated in every mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      alerm_equal <= 1'b0;
    end else begin
      alerm_equal <= alerm_switch && (hour == alarm_hour) && (min == alarm_min);
    end
  end

  // Display mux follows the mode combinationally.
  assign time_data = (mode_c == ALARM) ? {alarm_hour, alarm_min, FIELD_W'(0)}
                                       : {hour, min, sec};

endmodule

// File: tb/tb_watch_control.sv
// Directed bench for watch_control with a 4-cycle second.
module tb_watch_control;

  logic        clock;
  logic        reset;
  logic        set;
  logic        alerm;
  logic        alerm_switch;
  logic        minute_set;
  logic        hour_set;
  logic [23:0] time_data;
  logic        alerm_equal;

  int total;
  int bad;

  watch_control #(
    .second_cnt(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .set         (set),
    .alerm       (alerm),
    .alerm_switch(alerm_switch),
    .minute_set  (minute_set),
    .hour_set    (hour_set),
    .time_data   (time_data),
    .alerm_equal (alerm_equal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n falling edges; inputs are driven and outputs sampled there.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_time(input string tag, input logic [23:0] exp);
    #1;
    total++;
    assert (time_data === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, time_data, exp);
    end
  endtask

  task automatic chk_eq(input string tag, input logic exp);
    #1;
    total++;
    assert (alerm_equal === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, alerm_equal, exp);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    set          = 1'b0;
    alerm        = 1'b0;
    alerm_switch = 1'b0;
    minute_set   = 1'b0;
    hour_set     = 1'b0;

    // Reset state
    step(2);
    chk_time("reset_time", 24'h000000);
    chk_eq("reset_eq", 1'b0);

    // Free-run: first tick lands exactly 4 edges after release
    reset = 1'b0;
    step(3);
    chk_time("pre_first_tick", 24'h000000);
    step(1);
    chk_time("first_tick", 24'h000001);
    step(1196);
    chk_time("free_run_300", 24'h000500);
    chk_eq("free_run_eq", 1'b0);

    // Alarm display shows reset alarm 12:00
    alerm = 1'b1;
    chk_time("alarm_reset_disp", 24'h0C0000);
    alerm = 1'b0;

    // Set mode: 70 minute ticks from 00:05 wrap to 15 with no hour carry
    set        = 1'b1;
    minute_set = 1'b1;
    step(280);
    chk_time("set_minute_70", 24'h000F00);
    minute_set = 1'b0;
    hour_set   = 1'b1;
    step(120);
    chk_time("set_hour_30", 24'h060F00);
    minute_set = 1'b1;
    step(4);
    chk_time("set_both", 24'h071000);
    hour_set   = 1'b0;
    minute_set = 1'b1;
    step(2);
    minute_set = 1'b0;
    step(2);
    chk_time("short_press", 24'h071000);

    // Program 23:59 then roll over in Timer mode
    hour_set   = 1'b1;
    minute_set = 1'b1;
    step(64);
    hour_set   = 1'b0;
    step(108);
    minute_set = 1'b0;
    chk_time("set_2359", 24'h173B00);
    set = 1'b0;
    step(236);
    chk_time("at_235959", 24'h173B3B);
    step(4);
    chk_time("rollover", 24'h000000);

    // Priority: set wins over alerm, hour button adjusts the time
    set      = 1'b1;
    alerm    = 1'b1;
    hour_set = 1'b1;
    chk_time("prio_set_disp", 24'h000000);
    step(4);
    chk_time("prio_set_hour", 24'h010000);
    hour_set = 1'b0;
    set      = 1'b0;
    chk_time("prio_alarm_disp", 24'h0C0000);
    step(8);
    alerm = 1'b0;
    chk_time("time_runs_alarm", 24'h010002);
    alerm = 1'b1;

    // Program alarm to 01:01 (13 hour ticks, 1 minute tick)
    hour_set   = 1'b1;
    minute_set = 1'b1;
    step(4);
    minute_set = 1'b0;
    step(48);
    hour_set = 1'b0;
    chk_time("alarm_prog", 24'h010100);
    alerm        = 1'b0;
    alerm_switch = 1'b1;
    chk_time("time_after_prog", 24'h01000F);

    // Match window: rises one cycle after 01:01:00, lasts 240 cycles
    step(180);
    chk_time("minute_boundary", 24'h010100);
    chk_eq("eq_before_rise", 1'b0);
    step(1);
    chk_eq("eq_rise", 1'b1);
    step(239);
    chk_time("minute_end", 24'h010200);
    chk_eq("eq_last_cycle", 1'b1);
    step(1);
    chk_eq("eq_fall", 1'b0);

    // Move alarm to 01:02 to match again, then toggle the switch
    alerm      = 1'b1;
    minute_set = 1'b1;
    step(4);
    minute_set = 1'b0;
    alerm      = 1'b0;
    chk_eq("eq_rematch", 1'b1);
    alerm_switch = 1'b0;
    step(1);
    chk_eq("switch_off", 1'b0);
    alerm_switch = 1'b1;
    step(1);
    chk_eq("switch_on", 1'b1);

    // Reset on a tick edge clears everything
    reset = 1'b1;
    step(1);
    chk_time("reset_mid_time", 24'h000000);
    chk_eq("reset_mid_eq", 1'b0);
    alerm = 1'b1;
    chk_time("reset_mid_alarm", 24'h0C0000);
    alerm = 1'b0;
    reset = 1'b0;
    step(3);
    chk_time("restart_pre", 24'h000000);
    step(1);
    chk_time("restart_tick", 24'h000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
